// File: rtl/axi_slv_rchannel_pkg.sv
// axi_slv_rchannel_pkg: shared FSM encoding, frame field offsets and sizing constants
package axi_slv_rchannel_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;
    localparam int WORD_W         = 64;
    localparam int WORDS_PER_BEAT = 4;
    localparam int BEAT_W         = WORD_W * WORDS_PER_BEAT;
    localparam int CREDIT_INIT    = 32;
    localparam int FIFO_DEPTH     = 8;
    localparam int PTR_W          = 3;
    localparam int ADDR_W         = 22;
    localparam int FRAME_W        = 33;
    localparam int F_ADDR         = 0;
    localparam int F_RD           = 22;
    localparam int F_SOF          = 23;
    localparam int F_EOF          = 24;
    localparam int F_ARLEN        = 25;
endpackage

// File: rtl/axi_slv_rchannel_if.sv
// axi_slv_rchannel_if: AXI read channel plus arbiter frame/return signals
interface axi_slv_rchannel_if #(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_ADDR_WIDTH = 25
);
    logic                      axi_s_arvalid;
    logic                      axi_s_arready;
    logic [7:0]                axi_s_arlen;
    logic [AXI_ADDR_WIDTH-1:0] axi_s_araddr;
    logic                      axi_s_rvalid;
    logic                      axi_s_rready;
    logic                      axi_s_rlast;
    logic [AXI_DATA_WIDTH-1:0] axi_s_rdata;
    logic                      axi2arb_rframe_valid;
    logic                      axi2arb_rframe_ready;
    logic [32:0]               axi2arb_rframe_data;
    logic                      arb2axi_rdata_valid;
    logic [63:0]               arb2axi_rdata;
    modport slave (
        input  axi_s_arvalid, axi_s_arlen, axi_s_araddr, axi_s_rready,
               axi2arb_rframe_ready, arb2axi_rdata_valid, arb2axi_rdata,
        output axi_s_arready, axi_s_rvalid, axi_s_rlast, axi_s_rdata,
               axi2arb_rframe_valid, axi2arb_rframe_data
    );
    modport master (
        output axi_s_arvalid, axi_s_arlen, axi_s_araddr, axi_s_rready,
               axi2arb_rframe_ready, arb2axi_rdata_valid, arb2axi_rdata,
        input  axi_s_arready, axi_s_rvalid, axi_s_rlast, axi_s_rdata,
               axi2arb_rframe_valid, axi2arb_rframe_data
    );
endinterface

// File: rtl/sync_fifo_64to256.sv
// sync_fifo_64to256: packs 64-bit return words 4:1 into an 8-entry 256-bit FIFO (AXI_SLV_RCHANNEL_SVA_EN adds checks)
module sync_fifo_64to256
    import axi_slv_rchannel_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wvalid_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              rd_i,
    output logic [BEAT_W-1:0] rdata_o,
    output logic              empty_o
);
    logic [BEAT_W-WORD_W-1:0] pack_q;
    logic [1:0]               wcnt_q;
    logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]           cnt_q;
    logic [BEAT_W-1:0]        mem_q [FIFO_DEPTH];
    logic                     wr, rd;

    assign wr      = wvalid_i && (wcnt_q == 2'(WORDS_PER_BEAT - 1));
    assign rd      = rd_i && !empty_o;
    assign empty_o = (cnt_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // words shift in from the top so the first word of a beat ends up in [63:0]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q   <= '0;
            wcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            pack_q   <= wvalid_i ? {wdata_i, pack_q[BEAT_W-WORD_W-1:WORD_W]} : pack_q;
            wcnt_q   <= wcnt_q + 2'(wvalid_i);
            wr_ptr_q <= wr_ptr_q + PTR_W'(wr);
            rd_ptr_q <= rd_ptr_q + PTR_W'(rd);
            cnt_q    <= cnt_q + (PTR_W+1)'(wr) - (PTR_W+1)'(rd);
        end
    end

    // storage needs no reset: the output is forced to zero while empty
    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= {wdata_i, pack_q};
    end

`ifdef AXI_SLV_RCHANNEL_SVA_EN
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr && cnt_q == (PTR_W+1)'(FIFO_DEPTH)));
`else
    // default build carries no checker logic
`endif
endmodule

// File: rtl/axi_slv_rchannel.sv
// axi_slv_rchannel: AXI read slave splitting bursts into 64-bit arbiter frames (AXI_SLV_RCHANNEL_SVA_EN adds checks)
module axi_slv_rchannel
    import axi_slv_rchannel_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int AXI_ADDR_WIDTH = 25
) (
    input logic               clk,
    input logic               rst_n,
    axi_slv_rchannel_if.slave bus
);
    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          arlen_q, arlen_d, beat_q, beat_d;
    logic [9:0]          req_q, req_d;
    logic [5:0]          credit_q, credit_d;
    logic                arready_q, fvalid_q;
    logic                ar_hs, f_hs, r_hs, last_req, rvalid, rlast, sof, eof, fifo_empty;
    logic [BEAT_W-1:0]   fifo_dout;
    logic                unused_addr;

    assign unused_addr = ^bus.axi_s_araddr[2:0];
    assign ar_hs       = bus.axi_s_arvalid && arready_q;
    assign f_hs        = fvalid_q && bus.axi2arb_rframe_ready;
    assign rvalid      = !fifo_empty;
    assign r_hs        = rvalid && bus.axi_s_rready;
    assign rlast       = rvalid && (beat_q == arlen_q);
    assign last_req    = (req_q == {arlen_q, 2'b11});
    assign sof         = fvalid_q && (req_q == '0 || addr_q[5:0] == '0);
    assign eof         = (addr_q[5:0] == 6'h3f) || last_req;

    assign bus.axi_s_arready        = arready_q;
    assign bus.axi2arb_rframe_valid = fvalid_q;
    assign bus.axi_s_rvalid         = rvalid;
    assign bus.axi_s_rlast          = rlast;
    assign bus.axi_s_rdata          = AXI_DATA_WIDTH'(fifo_dout);

    // frame word: {arlen, eof, sof, read flag, 64-bit word address}
    always_comb begin
        bus.axi2arb_rframe_data                 = '0;
        bus.axi2arb_rframe_data[F_ADDR +: ADDR_W] = addr_q;
        bus.axi2arb_rframe_data[F_RD]           = 1'b0;
        bus.axi2arb_rframe_data[F_SOF]          = sof;
        bus.axi2arb_rframe_data[F_EOF]          = eof;
        bus.axi2arb_rframe_data[F_ARLEN +: 8]   = arlen_q;
    end

    // next state; credit counts free FIFO words, one per frame, four back per beat read
    always_comb begin
        state_d  = (state_q == IDLE) ? (ar_hs ? REQ : IDLE) :
                   (state_q == REQ)  ? ((f_hs && last_req) ? DRAIN : REQ) :
                   ((r_hs && rlast) ? IDLE : DRAIN);
        addr_d   = ar_hs ? bus.axi_s_araddr[AXI_ADDR_WIDTH-1:3] : addr_q + ADDR_W'(f_hs);
        arlen_d  = ar_hs ? bus.axi_s_arlen : arlen_q;
        req_d    = ar_hs ? '0 : req_q + 10'(f_hs);
        credit_d = credit_q - 6'(f_hs) + (r_hs ? 6'(WORDS_PER_BEAT) : 6'd0);
        beat_d   = (state_q == IDLE) ? '0 : beat_q + 8'(r_hs);
    end

    // FSM and counters with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            arlen_q   <= '0;
            req_q     <= '0;
            credit_q  <= 6'(CREDIT_INIT);
            beat_q    <= '0;
            arready_q <= 1'b1;
            fvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            arlen_q   <= arlen_d;
            req_q     <= req_d;
            credit_q  <= credit_d;
            beat_q    <= beat_d;
            arready_q <= (state_d == IDLE);
            fvalid_q  <= (state_d == REQ) && (credit_d != '0);
        end
    end

    sync_fifo_64to256 u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wvalid_i (bus.arb2axi_rdata_valid),
        .wdata_i  (bus.arb2axi_rdata),
        .rd_i     (bus.axi_s_rready),
        .rdata_o  (fifo_dout),
        .empty_o  (fifo_empty)
    );

`ifdef AXI_SLV_RCHANNEL_SVA_EN
    a_credit_over:  assert property (@(posedge clk) disable iff (!rst_n) credit_q <= 6'(CREDIT_INIT));
    a_credit_under: assert property (@(posedge clk) disable iff (!rst_n) !(f_hs && credit_q == '0));
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
                        rvalid && !bus.axi_s_rready |=> $stable(bus.axi_s_rdata) && $stable(bus.axi_s_rlast));
    a_idle_return:  assert property (@(posedge clk) disable iff (!rst_n) !(state_q == IDLE && bus.arb2axi_rdata_valid));
`else
    // default build carries no checker logic
`endif
endmodule

// File: tb/tb_axi_slv_rchannel.sv
// tb_axi_slv_rchannel: randomized bench with a burst-level reference model for axi_slv_rchannel
`timescale 1ns/1ps
module tb_axi_slv_rchannel;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [32:0]  fr_q[$];
    logic [63:0]  words_q[$];
    logic [255:0] beat_q[$];
    logic         last_q[$];
    bit   done;
    int   stall_bad, max_out, frames_at_hold;
    logic fv_at_hold;

    always #1.25 clk = ~clk;

    axi_slv_rchannel_if #(.AXI_DATA_WIDTH(256), .AXI_ADDR_WIDTH(25)) bus();
    axi_slv_rchannel #(.AXI_DATA_WIDTH(256), .AXI_ADDR_WIDTH(25)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic drive_idle();
        bus.axi_s_arvalid        = 1'b0;
        bus.axi_s_arlen          = '0;
        bus.axi_s_araddr         = '0;
        bus.axi_s_rready         = 1'b0;
        bus.axi2arb_rframe_ready = 1'b0;
        bus.arb2axi_rdata_valid  = 1'b0;
        bus.arb2axi_rdata        = '0;
    endtask

    // rmode: 0 ready, 1 held low until cycle hold, 2 toggle, 3 random; amode: 0 ready, 1 random
    task automatic run_burst(input logic [24:0] addr, input logic [7:0] len, input int rmode,
                             input int amode, input int hold, input int abort_at);
        logic [63:0]  pend[$];
        int           due[$];
        int           cyc = 0;
        bit           ar_pend = 1, stalled = 0, stop = 0;
        logic [255:0] sd;
        logic         ls;
        fr_q.delete(); words_q.delete(); beat_q.delete(); last_q.delete();
        done = 0; stall_bad = 0; max_out = 0; frames_at_hold = -1; fv_at_hold = 1'bx;
        bus.axi_s_araddr = addr;
        bus.axi_s_arlen  = len;
        while (!stop && cyc < 4000) begin
            bus.axi_s_arvalid        = ar_pend;
            bus.axi2arb_rframe_ready = (amode == 0) ? 1'b1 : 1'($urandom % 2);
            if (pend.size() > 0 && due[0] <= cyc) begin
                bus.arb2axi_rdata_valid = 1'b1;
                bus.arb2axi_rdata       = pend.pop_front();
                void'(due.pop_front());
                words_q.push_back(bus.arb2axi_rdata);
            end else begin
                bus.arb2axi_rdata_valid = 1'b0;
                bus.arb2axi_rdata       = {$urandom, $urandom};
            end
            case (rmode)
                0:       bus.axi_s_rready = 1'b1;
                1:       bus.axi_s_rready = (cyc >= hold);
                2:       bus.axi_s_rready = ~bus.axi_s_rready;
                default: bus.axi_s_rready = 1'($urandom % 2);
            endcase
            @(negedge clk);
            if (bus.axi_s_arvalid && bus.axi_s_arready) ar_pend = 0;
            if (bus.axi2arb_rframe_valid && bus.axi2arb_rframe_ready) begin
                fr_q.push_back(bus.axi2arb_rframe_data);
                pend.push_back({$urandom, $urandom});
                due.push_back(cyc + 1 + int'($urandom_range(0, 3)));
            end
            if (stalled && bus.axi_s_rvalid && (bus.axi_s_rdata !== sd || bus.axi_s_rlast !== ls)) stall_bad++;
            stalled = bus.axi_s_rvalid && !bus.axi_s_rready;
            sd = bus.axi_s_rdata;
            ls = bus.axi_s_rlast;
            if (bus.axi_s_rvalid && bus.axi_s_rready) begin
                beat_q.push_back(bus.axi_s_rdata);
                last_q.push_back(bus.axi_s_rlast);
                if (bus.axi_s_rlast) begin done = 1; stop = 1; end
            end
            if (int'(fr_q.size()) - 4 * int'(beat_q.size()) > max_out) max_out = int'(fr_q.size()) - 4 * int'(beat_q.size());
            if (cyc == hold) begin frames_at_hold = fr_q.size(); fv_at_hold = bus.axi2arb_rframe_valid; end
            if (abort_at != 0 && int'(fr_q.size()) >= abort_at) stop = 1;
            @(posedge clk); #0.2;
            cyc++;
        end
        drive_idle();
    endtask

    task automatic test_burst(input string name, input logic [24:0] addr, input logic [7:0] len,
                              input int rmode, input int amode, input int hold);
        int           n = (int'(len) + 1) * 4;
        logic [21:0]  ea;
        logic [32:0]  ef;
        logic [255:0] eb;
        run_burst(addr, len, rmode, amode, hold, 0);
        checks++;
        if (!done) begin errors++; $display("FAIL %s timeout: rlast beat not seen, got %0d beats, required %0d", name, beat_q.size(), int'(len) + 1); end
        checks++;
        if (int'(fr_q.size()) != n) begin errors++; $display("FAIL %s frame_count: got %0d required %0d", name, fr_q.size(), n); end
        for (int i = 0; i < n; i++) begin
            ea = addr[24:3] + 22'(i);
            ef = {len, (ea[5:0] == 6'h3f) || (i == n - 1), (i == 0) || (ea[5:0] == 6'h00), 1'b0, ea};
            checks++;
            if (i >= int'(fr_q.size())) begin errors++; $display("FAIL %s frame[%0d]: missing, required %h", name, i, ef); end
            else if (fr_q[i] !== ef) begin errors++; $display("FAIL %s frame[%0d]: got %h required %h", name, i, fr_q[i], ef); end
        end
        checks++;
        if (int'(beat_q.size()) != int'(len) + 1) begin errors++; $display("FAIL %s beat_count: got %0d required %0d", name, beat_q.size(), int'(len) + 1); end
        for (int k = 0; k <= int'(len); k++) begin
            checks++;
            if (k >= int'(beat_q.size()) || 4 * k + 3 >= int'(words_q.size())) begin
                errors++; $display("FAIL %s beat[%0d]: missing beat or return words", name, k);
            end else begin
                eb = {words_q[4*k+3], words_q[4*k+2], words_q[4*k+1], words_q[4*k]};
                if (beat_q[k] !== eb || last_q[k] !== (k == int'(len))) begin
                    errors++;
                    $display("FAIL %s beat[%0d]: got %h last %b required %h last %b", name, k, beat_q[k], last_q[k], eb, k == int'(len));
                end
            end
        end
        checks++;
        if (stall_bad != 0) begin errors++; $display("FAIL %s stall_stable: %0d changes while stalled, required 0", name, stall_bad); end
        checks++;
        if (max_out > 32) begin errors++; $display("FAIL %s credit: %0d words outstanding, required <= 32", name, max_out); end
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (bus.axi_s_arready !== 1'b1) begin errors++; $display("FAIL reset arready: got %b required 1", bus.axi_s_arready); end
        if (bus.axi_s_rvalid !== 1'b0) begin errors++; $display("FAIL reset rvalid: got %b required 0", bus.axi_s_rvalid); end
        if (bus.axi_s_rlast !== 1'b0) begin errors++; $display("FAIL reset rlast: got %b required 0", bus.axi_s_rlast); end
        if (bus.axi2arb_rframe_valid !== 1'b0) begin errors++; $display("FAIL reset rframe_valid: got %b required 0", bus.axi2arb_rframe_valid); end
        if (bus.axi_s_rdata !== '0) begin errors++; $display("FAIL reset rdata: got %h required 0", bus.axi_s_rdata); end
        @(posedge clk); #0.2;
        rst_n = 1'b1;
    endtask

    task automatic test_credit_stall();
        test_burst("credit_stall", 25'h40, 8'd15, 1, 0, 150);
        checks++;
        if (frames_at_hold != 32) begin errors++; $display("FAIL credit_stall frames_while_held: got %0d required 32", frames_at_hold); end
        checks++;
        if (fv_at_hold !== 1'b0) begin errors++; $display("FAIL credit_stall rframe_valid_while_held: got %b required 0", fv_at_hold); end
    endtask

    task automatic test_reset_mid();
        run_burst(25'h800, 8'd7, 3, 0, 0, 10);
        checks++;
        if (fr_q.size() != 10) begin errors++; $display("FAIL reset_mid frames_before_reset: got %0d required 10", fr_q.size()); end
        rst_n = 1'b0;
        @(negedge clk);
        checks += 5;
        if (bus.axi_s_arready !== 1'b1) begin errors++; $display("FAIL reset_mid arready: got %b required 1", bus.axi_s_arready); end
        if (bus.axi_s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_mid rvalid: got %b required 0", bus.axi_s_rvalid); end
        if (bus.axi_s_rlast !== 1'b0) begin errors++; $display("FAIL reset_mid rlast: got %b required 0", bus.axi_s_rlast); end
        if (bus.axi2arb_rframe_valid !== 1'b0) begin errors++; $display("FAIL reset_mid rframe_valid: got %b required 0", bus.axi2arb_rframe_valid); end
        if (bus.axi_s_rdata !== '0) begin errors++; $display("FAIL reset_mid rdata: got %h required 0", bus.axi_s_rdata); end
        @(posedge clk); #0.2;
        rst_n = 1'b1;
        test_burst("after_reset", 25'h1000, 8'd7, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++)
            test_burst("random", 25'($urandom), 8'($urandom_range(0, 7)), 3, 1, 0);
    endtask

    initial begin
        test_reset();
        test_burst("single_beat", 25'h0, 8'd0, 0, 0, 0);
        test_burst("sof_eof_boundary", 25'h1F0, 8'd0, 0, 0, 0);
        test_credit_stall();
        test_burst("rready_toggle", 25'h3A8, 8'd3, 2, 0, 0);
        test_burst("addr_wrap", 25'h1FFFFF8, 8'd0, 0, 0, 0);
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
